// File: rtl/rv_pkg.sv
// rv_pkg: shared integer-pipeline widths, register address/word types and fixed register indices.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] word_t;
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP = 5'd2;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback inputs, ID read ports and debug counter of the writeback stage.
interface wb_regfile_if #(
    parameter int DATA_W = 32
);
    import rv_pkg::*;
    logic              reg_write_en_in;
    logic              MemtoReg_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] mem_read_data_in;
    reg_addr_t         rd_addr_in;
    reg_addr_t         rs1_addr;
    reg_addr_t         rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] wb_data_out;
    logic              wb_commit;
    logic [31:0]       wb_count;
    modport master (
        output reg_write_en_in, MemtoReg_in, alu_result_in, mem_read_data_in, rd_addr_in,
               rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data_out, wb_commit, wb_count
    );
    modport slave (
        input  reg_write_en_in, MemtoReg_in, alu_result_in, mem_read_data_in, rd_addr_in,
               rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data_out, wb_commit, wb_count
    );
endinterface

// File: rtl/wb_regfile_rf_read_port.sv
// rf_read_port: one register-file read port with x0 forced to zero and same-cycle write-through bypass.
module rf_read_port
    import rv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  reg_addr_t         addr_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              byp_en_i,
    input  reg_addr_t         byp_addr_i,
    input  logic [DATA_W-1:0] byp_data_i,
    output logic [DATA_W-1:0] data_o
);
    // Array lookup and bypass compare are independent so they evaluate in parallel.
    logic              hit;
    logic [DATA_W-1:0] arr;
    always_comb begin
        hit = byp_en_i && (addr_i == byp_addr_i);
        arr = regs_i[addr_i];
        data_o = (addr_i == REG_ZERO) ? '0 : hit ? byp_data_i : arr;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback value select, 31-entry flop register file with async reset, two bypassed read ports.
module wb_regfile
    import rv_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] STACK_INIT = 32'h0000_0FFC
) (
    input logic       clk,
    input logic       rst_n,
    wb_regfile_if.slave bus
);
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_view [NUM_REGS];
    logic [DATA_W-1:0] wb_data;
    logic              commit;
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;
    always_comb begin
        wb_data = bus.MemtoReg_in ? bus.mem_read_data_in : bus.alu_result_in;
        commit = bus.reg_write_en_in && (bus.rd_addr_in != REG_ZERO);
        wb_count_d = wb_count_q + 32'd1;
    end
    // x0 has no storage; the read view supplies a constant zero in its slot.
    always_comb begin
        regs_view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) regs_view[i] = regs_q[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= (i == int'(REG_SP)) ? STACK_INIT : '0;
            wb_count_q <= '0;
        end else if (commit) begin
            regs_q[bus.rd_addr_in] <= wb_data;
            wb_count_q <= wb_count_d;
        end
    end
    rf_read_port #(.DATA_W(DATA_W)) u_rs1 (
        .addr_i     (bus.rs1_addr),
        .regs_i     (regs_view),
        .byp_en_i   (commit),
        .byp_addr_i (bus.rd_addr_in),
        .byp_data_i (wb_data),
        .data_o     (bus.rs1_data)
    );
    rf_read_port #(.DATA_W(DATA_W)) u_rs2 (
        .addr_i     (bus.rs2_addr),
        .regs_i     (regs_view),
        .byp_en_i   (commit),
        .byp_addr_i (bus.rd_addr_in),
        .byp_data_i (wb_data),
        .data_o     (bus.rs2_data)
    );
    assign bus.wb_data_out = wb_data;
    assign bus.wb_commit = commit;
    assign bus.wb_count = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors with a scoreboard queue; a negedge monitor pops and compares outputs.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if bus ();
    wb_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       nm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] wb;
        logic        commit;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "rs1_data", bus.rs1_data, e.rs1);
            chk(e.nm, "rs2_data", bus.rs2_data, e.rs2);
            chk(e.nm, "wb_data_out", bus.wb_data_out, e.wb);
            chk(e.nm, "wb_commit", {31'd0, bus.wb_commit}, {31'd0, e.commit});
            chk(e.nm, "wb_count", bus.wb_count, e.count);
        end
    end

    task automatic apply(input string nm, input logic rst, input logic en, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ewb,
                         input logic ecommit, input logic [31:0] ecount);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        bus.reg_write_en_in = en;
        bus.MemtoReg_in = m2r;
        bus.alu_result_in = alu;
        bus.mem_read_data_in = mem;
        bus.rd_addr_in = rd;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        e = '{nm, e1, e2, ewb, ecommit, ecount};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        bus.reg_write_en_in = 1'b0;
        bus.MemtoReg_in = 1'b0;
        bus.alu_result_in = '0;
        bus.mem_read_data_in = '0;
        bus.rd_addr_in = '0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        repeat (2) @(posedge clk);
        //    name        rst en m2r alu           mem           rd  a1  a2  exp rs1       exp rs2       exp wb        c  count
        apply("rst_idle", 1, 0, 0, 32'h0,        32'h0,        0,  2,  0,  32'h0000_0FFC, 32'h0,        32'h0,        0, 0);
        apply("alu_wb",   1, 1, 0, 32'hDEAD_BEEF, 32'h0,       5,  5,  2,  32'hDEAD_BEEF, 32'h0000_0FFC, 32'hDEAD_BEEF, 1, 0);
        apply("alu_rd",   1, 0, 0, 32'h0,        32'h0,        0,  5,  1,  32'hDEAD_BEEF, 32'h0,        32'h0,        0, 1);
        apply("ld_byp",   1, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 7, 7,  7,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1, 1);
        apply("x0_wr",    1, 1, 0, 32'hAAAA_AAAA, 32'h0,       0,  0,  7,  32'h0,        32'h1234_5678, 32'hAAAA_AAAA, 0, 2);
        apply("x3_wr",    1, 1, 0, 32'h33,       32'h0,        3,  3,  0,  32'h33,       32'h0,        32'h33,       1, 2);
        apply("dis_wr",   1, 0, 0, 32'h55,       32'h0,        3,  3,  3,  32'h33,       32'h33,       32'h55,       0, 3);
        apply("dis_rd",   1, 0, 0, 32'h0,        32'h0,        0,  3,  0,  32'h33,       32'h0,        32'h0,        0, 3);
        apply("sp_byp",   1, 1, 0, 32'h100,      32'h0,        2,  2,  5,  32'h100,      32'hDEAD_BEEF, 32'h100,      1, 3);
        apply("sp_rd",    1, 0, 0, 32'h0,        32'h0,        0,  2,  3,  32'h100,      32'h33,       32'h0,        0, 4);
        // Mid-run reset with a commit to x2 presented: bypass still serves it, array is cleared, commit lost.
        apply("rst_byp",  0, 1, 1, 32'h0,        32'h77,       2,  2,  5,  32'h77,       32'h0,        32'h77,       1, 0);
        apply("rst_hold", 0, 0, 0, 32'h0,        32'h0,        0,  2,  5,  32'h0000_0FFC, 32'h0,        32'h0,        0, 0);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            logic [4:0] b;
            a = 5'(i);
            b = 5'(31 - i);
            apply($sformatf("rst_scan%0d", i), 1, 0, 0, 32'h0, 32'h0, 0, a, b,
                  (i == 2) ? 32'h0000_0FFC : 32'h0, (i == 29) ? 32'h0000_0FFC : 32'h0, 32'h0, 0, 0);
        end
        apply("post_wr",  1, 1, 1, 32'h1,        32'h99,       9,  9,  9,  32'h99,       32'h99,       32'h99,       1, 0);
        apply("post_rd",  1, 0, 0, 32'h0,        32'h0,        0,  9,  7,  32'h99,       32'h0,        32'h0,        0, 1);
        // Preload the counter to its maximum so the next commit wraps it.
        #2;
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        apply("wrap_wr",  1, 1, 0, 32'h4,        32'h0,        4,  4,  0,  32'h4,        32'h0,        32'h4,        1, 32'hFFFF_FFFF);
        apply("wrap_rd",  1, 0, 0, 32'h0,        32'h0,        0,  4,  9,  32'h4,        32'h99,       32'h0,        0, 0);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file of the five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value (ALU result or load data) and commits it to a 32 × 32-bit register file. Serves the ID stage through two read ports with same-cycle write-through bypass. Exposes a committed-writeback counter for debug and CPI measurement.

## Interface
- DATA_W, 32, register and datapath width
- STACK_INIT, 32'h0000_0FFC, reset value of x2 (sp)
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_write_en_in  in  1  writeback enable from MEM/WB
- MemtoReg_in  in  1  1 = commit mem_read_data_in, 0 = commit alu_result_in
- alu_result_in  in  DATA_W  ALU result from MEM/WB
- mem_read_data_in  in  DATA_W  load data from MEM/WB
- rd_addr_in  in  5  destination register from MEM/WB
- rs1_addr  in  5  ID read port 1 address
- rs2_addr  in  5  ID read port 2 address
- rs1_data  out  DATA_W  ID read port 1 data (combinational)
- rs2_data  out  DATA_W  ID read port 2 data (combinational)
- wb_data_out  out  DATA_W  selected writeback value, to forwarding unit
- wb_commit  out  1  high when this cycle's writeback modifies architectural state
- wb_count  out  32  number of committed writebacks since reset

## Operation
- wb_data_out = MemtoReg_in ? mem_read_data_in : alu_result_in. Pure mux, no extension or shifting.
- wb_commit = reg_write_en_in && (rd_addr_in != 0).
- On a rising clk edge with wb_commit = 1: regs[rd_addr_in] <= wb_data_out. Otherwise the array holds.
- x0 has no storage. Reads of address 0 return 0. Writes to x0 are discarded and not counted.
- Read port n, with an address A:
  - If A == 0, returns 0.
  - Else if wb_commit and A == rd_addr_in, returns wb_data_out (write-through bypass).
  - Else returns regs[A].
  - Both ports apply the bypass independently, including when rs1_addr == rs2_addr == rd_addr_in.
- wb_count increments by 1 on each rising edge with wb_commit = 1. It wraps from 32'hFFFF_FFFF to 0 without saturating or flagging.
- Reset (rst_n low, asynchronous, mid-operation included):
  - All x1..x31 = 0, except x2 = STACK_INIT.
  - wb_count = 0.
  - Any writeback presented in the same cycle is lost.
  - rs1_data, rs2_data, wb_data_out and wb_commit remain combinational functions of their inputs during reset. A read of x2 returns STACK_INIT, unless a commit to x2 is presented that cycle, in which case the bypass applies.
- First rising edge after rst_n deasserts behaves normally.

## Timing
- Write latency: value committed at edge N is visible from regs after edge N. Through the bypass it is visible combinationally during cycle N, so ID never needs a WB→ID stall.
- Read ports, wb_data_out and wb_commit have zero latency, purely combinational. No registered outputs except wb_count.
- Critical path: MemtoReg mux → bypass compare/mux → rs*_data → ID/EX input setup. Keep the array read decode in parallel with the address compare.
- No handshake. The block accepts one writeback per cycle unconditionally. Stalling and flushing are handled upstream by zeroing reg_write_en_in.

## Structure
- Shared package rv_pkg holds:
  - XLEN = 32 and REG_ADDR_W = 5
  - typedef reg_addr_t and typedef word_t
  - constant REG_ZERO = 5'd0 and constant REG_SP = 5'd2
- One sub-module, rf_read_port: address, array view, bypass inputs → data. Instantiated twice to guarantee identical bypass logic on both ports.
- Array is implemented as flops, not inferred RAM, because every entry needs asynchronous reset.

## Test plan
- Reset: assert rst_n = 0 mid-run, then read all 32 addresses → x2 = 32'h0000_0FFC, all others 0, wb_count = 0.
- ALU writeback: en = 1, MemtoReg = 0, alu = 32'hDEAD_BEEF, rd = 5 → wb_commit = 1. Next cycle rs1_addr = 5 returns 32'hDEAD_BEEF and wb_count = 1.
- Load writeback with bypass: en = 1, MemtoReg = 1, mem = 32'h1234_5678, alu = 32'hFFFF_FFFF, rd = 7, with rs1_addr = rs2_addr = 7 in the same cycle → both ports return 32'h1234_5678 before the edge.
- x0 protection: en = 1, rd = 0, alu = 32'hAAAA_AAAA → wb_commit = 0, x0 reads 0, wb_count unchanged.
- Disabled write: en = 0, rd = 3, alu = 32'h55 → x3 stays at its prior value, no bypass, count unchanged.
- Counter wrap: force 2^32 − 1 commits, or preload via hierarchical force to 32'hFFFF_FFFF, then one commit → wb_count = 0.
